// File: rtl/hex_display_arbiter.sv
// Round-robin time-slice arbiter sharing one 4-digit hex display among NUM_REQ requesters.
// The owner keeps the display for at least HOLD_CYCLES cycles; all outputs are registered.
module hex_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_WIDTH   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [15:0]           values,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] HOLD_RELOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_INIT   = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state, state_n;
  logic [IDX_W-1:0]     last, last_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic [15:0]          values_n;
  logic                 busy_n;

  logic [15:0]          slot [NUM_REQ];
  logic [IDX_W-1:0]     pick;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W:0]       sum;
  logic                 found;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[16*g +: 16];
  end

  // Scan last+1, last+2, ... (mod NUM_REQ) for the first pending request.
  always_comb begin
    pick  = last;
    cand  = '0;
    sum   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, last} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    last_n   = last;
    cnt_n    = cnt;
    grant_n  = grant;
    values_n = values;
    busy_n   = busy;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          last_n        = pick;
          cnt_n         = HOLD_RELOAD;
          busy_n        = 1'b1;
          values_n      = slot[pick];
          state_n       = HOLD;
        end
      end
      HOLD: begin
        // In HOLD, last always names the current owner.
        values_n = slot[last];
        if (!req[last]) begin
          grant_n = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end else if ((req & ~grant) != '0) begin
          grant_n = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = HOLD_RELOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last   <= LAST_INIT;
      cnt    <= '0;
      grant  <= '0;
      values <= 16'h0000;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      cnt    <= cnt_n;
      grant  <= grant_n;
      values <= values_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed-vector bench for hex_display_arbiter with a 4-cycle hold slice.
module tb_hex_display_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data [4];
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic [15:0] values;
  logic        busy;

  int vectorCount;
  int missCount;

  assign req_data = {data[3], data[2], data[1], data[0]};

  hex_display_arbiter #(
    .NUM_REQ    (4),
    .HOLD_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .grant   (grant),
    .values  (values),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    tick();
  endtask

  // Pulse reset between edges so each scenario starts with last = 3.
  task automatic doReset();
    req = 4'b0000;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  logic [3:0]  rrGrant [19];
  logic [15:0] rrValue [19];

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rst = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) data[i] = 16'h0000;

    // Reset and first grant
    data[0] = 16'h1234;
    req = 4'b0001;
    tick();
    tick();
    checkOutput("rst_grant", {12'h0, grant}, 16'h0000);
    checkOutput("rst_values", values, 16'h0000);
    checkOutput("rst_busy", {15'h0, busy}, 16'h0000);
    req = 4'b0000;
    #2;
    rst = 1'b1;
    applyStimulus(4'b0000);
    checkOutput("idle_grant", {12'h0, grant}, 16'h0000);
    applyStimulus(4'b0001);
    checkOutput("first_grant", {12'h0, grant}, 16'h0001);
    checkOutput("first_busy", {15'h0, busy}, 16'h0001);
    checkOutput("first_values", values, 16'h1234);

    // Round-robin contention among requesters 0, 1 and 3
    doReset();
    data[0] = 16'hA000;
    data[1] = 16'hB111;
    data[3] = 16'hD333;
    rrGrant = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                4'b0001, 4'b0001, 4'b0001, 4'b0001};
    rrValue = '{16'hA000, 16'hA000, 16'hA000, 16'hA000, 16'hA000,
                16'hB111, 16'hB111, 16'hB111, 16'hB111, 16'hB111,
                16'hD333, 16'hD333, 16'hD333, 16'hD333, 16'hD333,
                16'hA000, 16'hA000, 16'hA000, 16'hA000};
    for (int i = 0; i < 19; i++) begin
      applyStimulus(4'b1011);
      checkOutput($sformatf("rr_grant[%0d]", i), {12'h0, grant}, {12'h0, rrGrant[i]});
      checkOutput($sformatf("rr_values[%0d]", i), values, rrValue[i]);
      checkOutput($sformatf("rr_busy[%0d]", i), {15'h0, busy}, {15'h0, (rrGrant[i] != 4'b0000)});
    end

    // Sole requester keeps the display with no gap cycles
    doReset();
    data[2] = 16'h2222;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0100);
      checkOutput($sformatf("sole_grant[%0d]", i), {12'h0, grant}, 16'h0004);
    end

    // Early drop by owner 1
    doReset();
    data[0] = 16'h0F0F;
    data[1] = 16'h5A5A;
    applyStimulus(4'b0010);
    checkOutput("drop_grant_a", {12'h0, grant}, 16'h0002);
    checkOutput("drop_values_a", values, 16'h5A5A);
    applyStimulus(4'b0010);
    checkOutput("drop_grant_b", {12'h0, grant}, 16'h0002);
    applyStimulus(4'b0000);
    checkOutput("drop_release", {12'h0, grant}, 16'h0000);
    checkOutput("drop_busy", {15'h0, busy}, 16'h0000);
    checkOutput("drop_values_hold", values, 16'h5A5A);
    data[1] = 16'hFFFF;
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkOutput("drop_idle_grant", {12'h0, grant}, 16'h0000);
    checkOutput("drop_idle_values", values, 16'h5A5A);
    applyStimulus(4'b0001);
    checkOutput("drop_next_grant", {12'h0, grant}, 16'h0001);
    checkOutput("drop_next_values", values, 16'h0F0F);

    // Live tracking of the owner's data
    doReset();
    data[0] = 16'h00FE;
    data[2] = 16'h1111;
    applyStimulus(4'b0001);
    checkOutput("live_fe", values, 16'h00FE);
    data[0] = 16'h00FF;
    #1;
    checkOutput("live_lag", values, 16'h00FE);
    applyStimulus(4'b0001);
    checkOutput("live_ff", values, 16'h00FF);
    data[0] = 16'h0100;
    applyStimulus(4'b0001);
    checkOutput("live_100", values, 16'h0100);
    data[2] = 16'h2222;
    applyStimulus(4'b0001);
    checkOutput("live_nonowner", values, 16'h0100);

    // Asynchronous reset in the middle of a slice
    doReset();
    data[0] = 16'h0A0A;
    data[2] = 16'h2B2B;
    data[3] = 16'h3C3C;
    applyStimulus(4'b0100);
    applyStimulus(4'b0100);
    checkOutput("async_pre_grant", {12'h0, grant}, 16'h0004);
    rst = 1'b0;
    #2;
    checkOutput("async_grant", {12'h0, grant}, 16'h0000);
    checkOutput("async_busy", {15'h0, busy}, 16'h0000);
    checkOutput("async_values", values, 16'h0000);
    req = 4'b1001;
    #1;
    rst = 1'b1;
    tick();
    checkOutput("async_winner", {12'h0, grant}, 16'h0001);
    checkOutput("async_winner_values", values, 16'h0A0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
